// File: rtl/ram_loader_16x8.sv
// ram_loader_16x8: 16x8 writable memory with a burst-write controller.
// A start command latches a base address and a word count. Bytes then
// stream in over a valid/ready handshake and land at auto-incrementing
// addresses. A combinational read port exposes the stored contents.
module ram_loader_16x8 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                wr_en;
  logic [ADDR_W:0]     len_clamped;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  // A request longer than the memory saturates at the full depth, so a
  // single burst can never lap the array and overwrite its own words.
  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] len);
    if (len > (ADDR_W+1)'(DEPTH)) begin
      return (ADDR_W+1)'(DEPTH);
    end
    return len;
  endfunction

  assign len_clamped = clamp_len(length);

  // Control registers: state, write pointer, words remaining, words written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and handshake decode; outputs depend only on the state so
  // in_ready never combinationally depends on in_valid.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    wr_en    = 1'b0;
    busy     = 1'b0;
    in_ready = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d   = start_addr;
          rem_d   = len_clamped;
          cnt_d   = '0;
          state_d = (len_clamped == '0) ? S_FINISH : S_LOAD;
        end
      end
      S_LOAD: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        // Abort wins over a same-cycle transfer: that byte is dropped.
        if (abort) begin
          state_d = S_IDLE;
        end else if (in_valid) begin
          wr_en = 1'b1;
          ptr_d = ptr_q + ADDR_W'(1);
          rem_d = rem_q - (ADDR_W+1)'(1);
          cnt_d = cnt_q + (ADDR_W+1)'(1);
          if (rem_q == (ADDR_W+1)'(1)) begin
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Storage array; reset wipes every word so stale data never survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[ptr_q] <= in_data;
    end
  end

  // Read port is asynchronous: a same-cycle write appears after the edge.
  assign rd_data  = mem_q[rd_addr];
  assign wr_count = cnt_q;

endmodule

// File: tb/tb_ram_loader_16x8.sv
// Self-checking bench for ram_loader_16x8: table-driven bursts with a
// write scoreboard, plus hand-written abort / restart / reset sequences.
module tb_ram_loader_16x8;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   length;
  logic              abort;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   wr_count;

  ram_loader_16x8 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .length(length), .abort(abort), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [3:0] sa;
    logic [4:0] len;
    logic [7:0] mask;
    logic [7:0] d0;
    logic [7:0] step;
    logic [4:0] cnt;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  logic [7:0] ref_mem [DEPTH];
  wr_t  sb_q [$];
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop every recorded write and read it back, then sweep the whole array.
  task automatic drain();
    wr_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      rd_addr = e.addr;
      #1;
      chk($sformatf("sb_rd[%0h]", e.addr), 32'(rd_data), 32'(e.data));
    end
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = 4'(a);
      #1;
      chk($sformatf("sweep[%0h]", a), 32'(rd_data), 32'(ref_mem[a]));
    end
  endtask

  task automatic send(input logic [3:0] p, input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    ref_mem[p] = d;
    sb_q.push_back('{addr: p, data: d});
  endtask

  task automatic run_burst(input vec_t v);
    int n, sent, cyc;
    logic [3:0] p;
    logic [7:0] d;
    bit fin;
    n = (v.len > 5'd16) ? 16 : int'(v.len);
    chk("idle_busy", 32'(busy), 32'(0));
    chk("idle_ready", 32'(in_ready), 32'(0));
    start = 1'b1; start_addr = v.sa; length = v.len;
    tick();
    start = 1'b0; start_addr = ~v.sa; length = 5'd0;
    cyc = 1; sent = 0; p = v.sa; d = v.d0; fin = (n == 0);
    if (n == 0) begin
      chk("len0_ready", 32'(in_ready), 32'(0));
    end
    while (!fin && cyc < 100) begin
      chk("load_busy", 32'(busy), 32'(1));
      chk("load_ready", 32'(in_ready), 32'(1));
      chk("load_done", 32'(done), 32'(0));
      if (v.mask[(cyc - 1) % 8]) begin
        send(p, d);
        p = p + 4'd1;
        d = d + v.step;
        sent++;
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
      tick();
      in_valid = 1'b0;
      cyc++;
      if (sent == n) fin = 1'b1;
    end
    if (!fin) chk("burst_timeout", 32'(sent), 32'(n));
    chk("done_pulse", 32'(done), 32'(1));
    chk("finish_ready", 32'(in_ready), 32'(0));
    chk("wr_count", 32'(wr_count), 32'(v.cnt));
    tick();
    chk("done_clear", 32'(done), 32'(0));
    chk("post_busy", 32'(busy), 32'(0));
    chk("wr_count_hold", 32'(wr_count), 32'(v.cnt));
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{sa: 4'h2, len: 5'd4,  mask: 8'hFF, d0: 8'hAA, step: 8'h11, cnt: 5'd4};
    vecs[1] = '{sa: 4'hE, len: 5'd3,  mask: 8'hFF, d0: 8'h11, step: 8'h11, cnt: 5'd3};
    vecs[2] = '{sa: 4'h7, len: 5'd2,  mask: 8'h99, d0: 8'h5A, step: 8'h4B, cnt: 5'd2};
    vecs[3] = '{sa: 4'h5, len: 5'd0,  mask: 8'hFF, d0: 8'h00, step: 8'h00, cnt: 5'd0};
    vecs[4] = '{sa: 4'h3, len: 5'd20, mask: 8'hFF, d0: 8'h01, step: 8'h07, cnt: 5'd16};
    vecs[5] = '{sa: 4'h0, len: 5'd5,  mask: 8'hB6, d0: 8'hC0, step: 8'h01, cnt: 5'd5};

    rst = 1'b1; start = 1'b0; start_addr = '0; length = '0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; rd_addr = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_ready", 32'(in_ready), 32'(0));
    chk("rst_count", 32'(wr_count), 32'(0));
    drain();

    foreach (vecs[i]) run_burst(vecs[i]);

    // start held during LOAD and FINISH must not re-latch anything
    start = 1'b1; start_addr = 4'h0; length = 5'd3;
    tick();
    start_addr = 4'h9; length = 5'd1;
    for (int i = 0; i < 3; i++) begin
      chk("restart_busy", 32'(busy), 32'(1));
      send(4'(i), 8'(8'h60 + i));
      tick();
    end
    in_valid = 1'b0;
    chk("restart_done", 32'(done), 32'(1));
    chk("restart_count", 32'(wr_count), 32'(3));
    tick();
    start = 1'b0;
    chk("finish_start_busy", 32'(busy), 32'(0));
    chk("finish_start_count", 32'(wr_count), 32'(3));
    drain();

    // abort with the third byte: that byte is dropped, no done pulse
    start = 1'b1; start_addr = 4'h8; length = 5'd8;
    tick();
    start = 1'b0;
    send(4'h8, 8'h71);
    tick();
    send(4'h9, 8'h72);
    tick();
    in_valid = 1'b1; in_data = 8'hEE; abort = 1'b1;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_count", 32'(wr_count), 32'(2));
    tick();
    chk("abort_done2", 32'(done), 32'(0));
    drain();

    // asynchronous reset in the middle of a burst
    start = 1'b1; start_addr = 4'h4; length = 5'd6;
    tick();
    start = 1'b0;
    send(4'h4, 8'h91);
    tick();
    send(4'h5, 8'h92);
    tick();
    in_valid = 1'b1; in_data = 8'h93;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_ready", 32'(in_ready), 32'(0));
    chk("midrst_done", 32'(done), 32'(0));
    chk("midrst_count", 32'(wr_count), 32'(0));
    in_valid = 1'b0;
    sb_q.delete();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_done2", 32'(done), 32'(0));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
